// File: rtl/hex_entry.sv
// hex_entry: four-button hexadecimal value editor with a cursor and a
// valid/ready commit port. Buttons: [0] inc, [1] dec, [2] cursor, [3] commit.
// Optional build macro HEX_ENTRY_REPEAT_EN enables auto-repeat of inc/dec
// while held; without it every action needs a distinct press.
module hex_entry #(
  parameter logic [23:0] REPEAT_DELAY = 24'd12_000_000,
  parameter logic [23:0] REPEAT_RATE  = 24'd3_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn,
  output logic [15:0] value,
  output logic [1:0]  cursor,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  localparam logic [23:0] CNT_SAT = 24'hFF_FFFF;

  // Reject parameter values that would make the repeat timing meaningless.
  if (REPEAT_DELAY < 24'd2) begin : g_bad_delay
    $error("hex_entry: REPEAT_DELAY must be at least 2");
  end
  if (REPEAT_RATE < 24'd1) begin : g_bad_rate
    $error("hex_entry: REPEAT_RATE must be at least 1");
  end

  // Lowest set bit wins when several buttons go down in the same cycle.
  function automatic logic [1:0] lowest_index(input logic [3:0] p);
    logic [1:0] idx;
    if (p[0]) begin
      idx = 2'd0;
    end else if (p[1]) begin
      idx = 2'd1;
    end else if (p[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  logic [3:0]  btn_q;
  logic [15:0] value_q, value_d;
  logic [1:0]  cursor_q, cursor_d;
  logic [15:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  state_e      state_q, state_d;
  logic [1:0]  trk_q, trk_d;
  logic [23:0] cnt_q, cnt_d;

  logic [3:0]  press_s;
  logic        act_s;
  logic [1:0]  act_idx_s;
  logic [3:0]  nib_s;

  assign press_s = btn & ~btn_q;
  assign nib_s   = value_q[{cursor_q, 2'b00} +: 4];

  // Tracking FSM: accepts one press at a time and schedules repeat steps.
  always_comb begin
    state_d   = state_q;
    trk_d     = trk_q;
    cnt_d     = cnt_q;
    act_s     = 1'b0;
    act_idx_s = trk_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 24'd0;
        if (press_s != 4'b0000) begin
          act_s     = 1'b1;
          act_idx_s = lowest_index(press_s);
          trk_d     = lowest_index(press_s);
          state_d   = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!btn[trk_q]) begin
          state_d = ST_IDLE;
          cnt_d   = 24'd0;
`ifdef HEX_ENTRY_REPEAT_EN
        end else if ((trk_q[1] == 1'b0) && (cnt_q == REPEAT_DELAY - 24'd1)) begin
          // Only inc/dec (indices 0 and 1) ever auto-repeat.
          act_s   = 1'b1;
          cnt_d   = 24'd0;
          state_d = ST_REPEAT;
`endif
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 24'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_REPEAT: begin
`ifdef HEX_ENTRY_REPEAT_EN
        if (!btn[trk_q]) begin
          state_d = ST_IDLE;
          cnt_d   = 24'd0;
        end else if (cnt_q == REPEAT_RATE - 24'd1) begin
          act_s = 1'b1;
          cnt_d = 24'd0;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
`else
        // Unreachable without auto-repeat; fall back to a safe state.
        state_d = ST_IDLE;
        cnt_d   = 24'd0;
`endif
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 24'd0;
      end
    endcase
  end

  // Datapath: apply the selected action and run the commit handshake.
  always_comb begin
    value_d     = value_q;
    cursor_d    = cursor_q;
    out_data_d  = out_data_q;
    // A transfer retires the pending word; commits below still see the old flag.
    out_valid_d = out_valid_q & ~out_ready;
    if (act_s) begin
      case (act_idx_s)
        2'd0: value_d[{cursor_q, 2'b00} +: 4] = nib_s + 4'd1;
        2'd1: value_d[{cursor_q, 2'b00} +: 4] = nib_s - 4'd1;
        2'd2: cursor_d = cursor_q + 2'd1;
        2'd3: begin
          if (!out_valid_q) begin
            out_data_d  = value_q;
            out_valid_d = 1'b1;
          end else begin
            out_data_d = out_data_q;
          end
        end
        default: value_d = value_q;
      endcase
    end else begin
      value_d = value_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_q       <= 4'b1111;
      value_q     <= 16'h0000;
      cursor_q    <= 2'd0;
      out_data_q  <= 16'h0000;
      out_valid_q <= 1'b0;
      state_q     <= ST_IDLE;
      trk_q       <= 2'd0;
      cnt_q       <= 24'd0;
    end else begin
      btn_q       <= btn;
      value_q     <= value_d;
      cursor_q    <= cursor_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      state_q     <= state_d;
      trk_q       <= trk_d;
      cnt_q       <= cnt_d;
    end
  end

  assign value     = value_q;
  assign cursor    = cursor_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_hex_entry.sv
// Scoreboard bench for hex_entry: a behavioural model (held-time arithmetic)
// pushes the expected outputs for every edge; a monitor pops and compares.
module tb_hex_entry;

  localparam logic [23:0] DLY = 24'd10;
  localparam logic [23:0] RATE = 24'd4;
`ifdef HEX_ENTRY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  btn = 4'b0000;
  logic        out_ready = 1'b0;
  logic [15:0] value, out_data;
  logic [1:0]  cursor;
  logic        out_valid;

  hex_entry #(.REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)) dut (
    .clk(clk), .rst(rst), .btn(btn), .value(value), .cursor(cursor),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [34:0] exp_q[$];

  // Reference model state
  logic [15:0] m_val = 16'h0000;
  logic [15:0] m_od = 16'h0000;
  logic [1:0]  m_cur = 2'd0;
  logic        m_ov = 1'b0;
  logic [3:0]  m_prev = 4'hF;
  int          m_trk = -1;
  int          m_el = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock edge of the specified behaviour.
  task automatic model_step(input logic [3:0] b, input logic r, input logic rdy);
    int act;
    int sh;
    logic [3:0] press;
    logic [3:0] nib;
    logic new_ov;
    act = -1;
    if (!r) begin
      m_val = 16'h0000; m_od = 16'h0000; m_cur = 2'd0; m_ov = 1'b0;
      m_prev = 4'hF; m_trk = -1; m_el = 0;
    end else begin
      if (m_trk >= 0) begin
        if (!b[m_trk]) begin
          m_trk = -1;
        end else begin
          m_el++;
          if (REP_EN && m_trk < 2 && m_el >= int'(DLY) &&
              ((m_el - int'(DLY)) % int'(RATE)) == 0) act = m_trk;
        end
      end else begin
        press = b & ~m_prev;
        for (int i = 3; i >= 0; i--) if (press[i]) act = i;
        if (act >= 0) begin
          m_trk = act;
          m_el = 0;
        end
      end
      new_ov = m_ov && !rdy;
      sh = 4 * int'(m_cur);
      nib = 4'((m_val >> sh) & 16'h000F);
      if (act == 0 || act == 1) begin
        nib = (act == 0) ? 4'((int'(nib) + 1) % 16) : 4'((int'(nib) + 15) % 16);
        m_val = (m_val & ~(16'h000F << sh)) | (16'(nib) << sh);
      end else if (act == 2) begin
        m_cur = 2'((int'(m_cur) + 1) % 4);
      end else if (act == 3 && !m_ov) begin
        m_od = m_val;
        new_ov = 1'b1;
      end
      m_ov = new_ov;
      m_prev = b;
    end
  endtask

  task automatic tick(input logic [3:0] b, input logic r, input logic rdy);
    @(negedge clk);
    btn = b; rst = r; out_ready = rdy;
    model_step(b, r, rdy);
    exp_q.push_back({m_val, m_cur, m_ov, m_od});
  endtask

  task automatic press(input int idx);
    logic [3:0] b;
    b = 4'b0001 << idx;
    tick(b, 1'b1, 1'b0);
    tick(4'b0000, 1'b1, 1'b0);
  endtask

  // Wait for the edge that applies the last driven inputs.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare every presented output against the scoreboard.
  initial begin
    logic [34:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("value", value, e[34:19]);
        check("cursor", {14'd0, cursor}, {14'd0, e[18:17]});
        check("out_valid", {15'd0, out_valid}, {15'd0, e[16]});
        check("out_data", out_data, e[15:0]);
      end
    end
  end

  initial begin
    logic [3:0] rb;
    int len;
    repeat (3) tick(4'b0000, 1'b0, 1'b0);
    tick(4'b0000, 1'b1, 1'b0);

    // Basic editing
    repeat (3) press(0);
    press(2);
    press(1);
    settle();
    check("s1_value", value, 16'h00F3);
    check("s1_cursor", {14'd0, cursor}, 16'd1);

    // Cursor wrap and nibble wrap without carry
    repeat (3) press(2);
    repeat (4) press(1);
    press(0);
    settle();
    check("s2_value", value, 16'h00F0);
    check("s2_cursor", {14'd0, cursor}, 16'd0);

    // Held increment
    repeat (22) tick(4'b0001, 1'b1, 1'b0);
    tick(4'b0000, 1'b1, 1'b0);
    settle();
    check("s3_hold", value, REP_EN ? 16'h00F4 : 16'h00F1);

    // Simultaneous presses: lowest index wins
    tick(4'b0101, 1'b1, 1'b0);
    tick(4'b0000, 1'b1, 1'b0);
    press(2);
    settle();
    check("s4_value", value, REP_EN ? 16'h00F5 : 16'h00F2);
    check("s4_cursor", {14'd0, cursor}, 16'd1);

    // Commit handshake
    tick(4'b0000, 1'b0, 1'b0);
    tick(4'b0000, 1'b1, 1'b0);
    repeat (4) press(0);
    press(2);
    repeat (3) press(0);
    press(2);
    repeat (2) press(0);
    press(2);
    press(0);
    press(3);
    settle();
    check("s5_valid", {15'd0, out_valid}, 16'd1);
    check("s5_data", out_data, 16'h1234);
    press(2);
    press(0);
    press(3);
    settle();
    check("s5_drop", out_data, 16'h1234);
    check("s5_value", value, 16'h1235);
    tick(4'b0000, 1'b1, 1'b1);
    settle();
    check("s5_accept", {15'd0, out_valid}, 16'd0);
    tick(4'b0000, 1'b1, 1'b0);

    // Button held through reset, then reset during repeat with a word pending
    repeat (3) tick(4'b0001, 1'b0, 1'b0);
    repeat (3) tick(4'b0001, 1'b1, 1'b0);
    settle();
    check("s6_held", value, 16'h0000);
    tick(4'b0000, 1'b1, 1'b0);
    press(0);
    settle();
    check("s6_repress", value, 16'h0001);
    press(3);
    repeat (15) tick(4'b0001, 1'b1, 1'b0);
    tick(4'b0001, 1'b0, 1'b0);
    settle();
    check("s6_rst_value", value, 16'h0000);
    check("s6_rst_valid", {15'd0, out_valid}, 16'd0);
    check("s6_rst_data", out_data, 16'h0000);
    tick(4'b0000, 1'b1, 1'b0);

    // Randomized holds, presses, resets and consumer back-pressure
    for (int s = 0; s < 150; s++) begin
      rb = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      len = $urandom_range(1, 25);
      for (int c = 0; c < len; c++) begin
        tick(rb, ($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)));
      end
    end

    tick(4'b0000, 1'b1, 1'b0);
    tick(4'b0000, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hex_entry.md
# hex_entry

Button-driven hexadecimal value editor: turns four debounced push-button levels into a 16-bit value edited one nibble at a time, with a cursor and a commit handshake toward the consumer. It is the input-side counterpart of the 4-digit seven-segment display path. The display shows `value` and `cursor`, and the core or debug logic receives committed words through a valid/ready handshake. It sits between the button debouncer outputs and the core/debug bus in the top-level board wrapper.

## Interface
- `REPEAT_DELAY`, default 24'd12_000_000: clocks a step button must stay held before auto-repeat starts. Must be ≥2.
- `REPEAT_RATE`, default 24'd3_000_000: clocks between auto-repeat steps once repeating. Must be ≥1.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `btn`  in  4  debounced button levels, active-high:
  - [0] increment the digit at the cursor.
  - [1] decrement the digit at the cursor.
  - [2] move the cursor left.
  - [3] commit.
- `value`  out  16  working value under edit; drives the display.
- `cursor`  out  2  selected nibble; 0 is the least-significant nibble, bits [3:0].
- `out_data`  out  16  committed word; stable while `out_valid` is high.
- `out_valid`  out  1  committed word pending.
- `out_ready`  in  1  consumer accepts `out_data` in a cycle where `out_valid && out_ready`.

## Operation
- Edge detection:
  - `btn_q` is a registered copy of `btn`.
  - A press is `btn & ~btn_q`.
  - Reset loads `btn_q` to 4'b1111, so a button already held during reset must be released and pressed again before it acts.
- Press arbitration:
  - Only one button is tracked at a time.
  - A press is accepted only while the FSM is IDLE.
  - If several presses occur in the same cycle, the lowest index wins; the others are ignored until released and pressed again.
- Actions:
  - inc: `value[4*cursor +: 4]` ← +1 mod 16 (F→0), no carry into other nibbles.
  - dec: −1 mod 16 (0→F), no borrow.
  - cursor: `cursor` ← `cursor`+1 mod 4 (3→0).
  - commit: if `out_valid`==0, `out_data` ← `value` and `out_valid` ← 1. If `out_valid`==1, the commit is dropped: `out_data` is unchanged and `value` is unaffected.
- Handshake:
  - `out_valid` clears on the edge where `out_valid && out_ready`.
  - A commit in that same cycle is still dropped, because it checks the pre-edge `out_valid`.
  - `out_ready` with `out_valid`==0 has no effect.
- FSM states:
  - IDLE: waits for a press. An accepted press performs its action and goes to HOLD, tracking that button. The repeat counter is cleared.
  - HOLD: the tracked button is still high.
    - Tracked button low → IDLE.
    - Tracked button is inc/dec, the counter reaches `REPEAT_DELAY`−1, and repeat is enabled → perform one step, clear the counter, go to REPEAT.
    - Cursor and commit never repeat.
  - REPEAT:
    - Tracked button low → IDLE.
    - Counter reaches `REPEAT_RATE`−1 → one step, clear the counter.
- Repeat counter: 24 bits, counts only in HOLD/REPEAT, saturates (cannot wrap) in HOLD when repeat is disabled.
- Reset values:
  - `value`=16'h0000, `cursor`=0.
  - `out_data`=16'h0000, `out_valid`=0.
  - FSM=IDLE, counter=0.
- Reset asserted mid-operation, including mid-repeat or with `out_valid` pending, returns everything to the reset values at that edge. A pending word is discarded.

## Timing
- A press is detected in the first cycle where `btn` is high and `btn_q` is low.
- The action is applied on that same edge, so the new `value`/`cursor`/`out_valid` is visible the following cycle (1-clock latency).
- The first auto-repeat step occurs `REPEAT_DELAY` clocks after the press edge. Subsequent steps follow every `REPEAT_RATE` clocks.
- Release ends tracking on the first edge where the tracked bit is sampled low. A new press of any button is accepted no earlier than the next cycle.
- No combinational path from `btn` or `out_ready` to any output.

## Configuration
- `HEX_ENTRY_REPEAT_EN`:
  - Defined: HOLD→REPEAT auto-repeat as specified for inc/dec.
  - Undefined: no repeat logic is compiled. HOLD only waits for release, and every action needs a distinct press. The parameters are accepted but unused.

## Test plan
All scenarios use `REPEAT_DELAY`=10 and `REPEAT_RATE`=4.
- After reset, press inc 3 times, cursor once, dec once → `value`=16'h00F3, `cursor`=1.
- Cursor pressed 4 times from 0 → returns to 0. With nibble 0 = F, inc → nibble 0 = 0 and `value[15:4]` unchanged.
- Hold inc for 22 clocks from the press edge with `HEX_ENTRY_REPEAT_EN` defined → increments at clocks 0, 10, 14, 18 (4 total). Without the macro → exactly 1.
- Press inc and cursor in the same cycle → only inc acts. Release both, then press cursor → `cursor`=1.
- Commit with `value`=16'h1234 and `out_ready`=0 → `out_valid`=1 next cycle, `out_data`=16'h1234. Edit to 16'h1235 and commit again → `out_data` stays 16'h1234. Assert `out_ready` → `out_valid`=0 next cycle.
- Hold inc through reset and deassert reset while still held → no increment until release and re-press. Reset during REPEAT with `out_valid`=1 → all outputs at reset values next cycle.
